sipo_deser: RTL

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_deser_if.sv | 31 +++
 rtl/sipo_bitcnt.sv | 53 +++++
 rtl/sipo_deser.sv | 114 +++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and types for the serial-in/parallel-out deserializer.
// Holds the default word width, the counter-width helper and the output FSM state type.
package sipo_pkg;

  localparam int SIPO_WIDTH = 4;
  localparam int SIPO_CNT_W = $clog2(SIPO_WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sipo_state_e;

  // Keeps the counter at least one bit wide for the smallest legal word.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel output handshake bundle for sipo_deser.
// The master drives the serial stream and consumer ready; the slave is the deserializer.
interface sipo_deser_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
);

  logic             si;
  logic             si_valid;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;

  modport master (
    output si,
    output si_valid,
    output po_ready,
    input  po,
    input  po_valid
  );

  modport slave (
    input  si,
    input  si_valid,
    input  po_ready,
    output po,
    output po_valid
  );

endinterface

// File: rtl/sipo_bitcnt.sv
// Bit counter for the partial word; wrap flags the bit that completes a word.
// clr wins over inc, so a cleared cycle never reports a wrap.
module sipo_bitcnt
  import sipo_pkg::*;
#(
  parameter  int WIDTH = SIPO_WIDTH,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             wrap_s;

  assign wrap_s = inc & ~clr & (count_q == LAST);

  // Next count: clear, wrap at the last bit, advance, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (wrap_s) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_s;

endmodule

// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel deserializer with a one-word output register,
// valid/ready handshake and a sticky overflow flag for words dropped while full.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter  int WIDTH = SIPO_WIDTH,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  sipo_deser_if.slave      bus,
  output logic             overflow,
  output logic [CNT_W-1:0] bit_cnt
);

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] word_s;
  logic             sample_s;
  logic             done_s;

  assign sample_s = bus.si_valid & ~clr;
  assign word_s   = {bus.si, shift_q[WIDTH-1:1]};

  sipo_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sample_s),
    .clr   (clr),
    .count (bit_cnt),
    .wrap  (done_s)
  );

  // Shift register: new bits enter at the top so the first bit ends up in bit 0.
  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (bus.si_valid) begin
      shift_d = word_s;
    end else begin
      shift_d = shift_q;
    end
  end

  // Output FSM: load on completion, drop and flag when the held word is not taken.
  always_comb begin
    state_d    = state_q;
    po_d       = po_q;
    overflow_d = overflow_q;
    case (state_q)
      EMPTY: begin
        if (done_s) begin
          state_d = FULL;
          po_d    = word_s;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (done_s) begin
          state_d = FULL;
          if (bus.po_ready) begin
            po_d = word_s;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (bus.po_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_d;
    end
    po_valid_d = (state_d == FULL);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      shift_q    <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = po_valid_q;
  assign overflow     = overflow_q;

endmodule
